// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer type and Gray-code helpers shared by the FIFO read and write controllers.
package fifo_pkg;

    localparam int ADDR_W = 4;

    typedef logic [ADDR_W:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_sync.sv
// fifo_wr_ctrl_sync: width-parameterised two-flop synchronizer for Gray-coded pointers.
module fifo_wr_ctrl_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer, RAM write port and full/level/overflow flags of the async FIFO.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = fifo_pkg::ADDR_W,
    parameter int AF_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rptr_gray_async,
    input  logic              ovf_clr,
    output logic              wr_commit,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rq_sync;
    logic [ADDR_W:0] rbin_s;
    logic [ADDR_W:0] level_next;
    logic [ADDR_W:0] full_match;

    fifo_wr_ctrl_sync #(
        .WIDTH(ADDR_W + 1)
    ) u_rptr_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rptr_gray_async),
        .q    (rq_sync)
    );

    assign wr_commit  = wr_en & ~full;
    assign waddr      = wbin[ADDR_W-1:0];
    assign wbin_next  = wbin + (ADDR_W + 1)'(wr_commit);
    assign wgray_next = bin2gray(wbin_next);
    assign rbin_s     = gray2bin(rq_sync);
    // Synchronized read pointer lags, so this level can only over-estimate occupancy.
    assign level_next = wbin_next - rbin_s;
    // Full: write pointer one lap ahead, i.e. Gray MSBs inverted, remaining bits equal.
    assign full_match = {~rq_sync[ADDR_W:ADDR_W-1], rq_sync[ADDR_W-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == full_match);
            almost_full <= (level_next >= AF_LVL);
            wr_level    <= level_next;
            overflow    <= (overflow & ~ovf_clr) | (wr_en & full);
        end
    end

endmodule
